// File: rtl/core_audio_pkg.sv
// Shared constants and types for the audio receive path.
package core_audio_pkg;

  localparam int unsigned SampleBitsDefault = 16;
  localparam int unsigned SlotBitsDefault   = 32;

  // I2S word-select encoding: LRCK low is the left channel.
  typedef enum logic {
    ChLeft  = 1'b0,
    ChRight = 1'b1
  } channel_e;

  // Counter width able to hold values 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_ff2.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_ff2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/i2s_receiver.sv
// I2S slave receiver: oversamples SCLK/LRCK/SDIN in the clk_74a domain and
// presents complete left/right pairs on a valid/ready handshake.
module i2s_receiver
  import core_audio_pkg::*;
#(
  parameter int unsigned SAMPLE_BITS = SampleBitsDefault,
  parameter int unsigned SLOT_BITS   = SlotBitsDefault
) (
  input  logic                   clk_74a,
  input  logic                   reset_n,
  input  logic                   i2s_sclk,
  input  logic                   i2s_lrck,
  input  logic                   i2s_sdin,
  output logic [SAMPLE_BITS-1:0] sample_left,
  output logic [SAMPLE_BITS-1:0] sample_right,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic                   locked,
  output logic                   overrun,
  output logic                   frame_err,
  input  logic                   err_clr
);

  localparam int unsigned CntW = cnt_width(SLOT_BITS);
  localparam logic [CntW-1:0] SlotMax   = CntW'(SLOT_BITS);
  localparam logic [CntW-1:0] SampleCnt = CntW'(SAMPLE_BITS);
  localparam logic [CntW-1:0] LastBit   = CntW'(SAMPLE_BITS - 1);

  logic sclk_s;
  logic lrck_s;
  logic sdin_s;

  sync_ff2 u_sync_sclk (
    .clk_i  (clk_74a),
    .rst_ni (reset_n),
    .d_i    (i2s_sclk),
    .q_o    (sclk_s)
  );

  sync_ff2 u_sync_lrck (
    .clk_i  (clk_74a),
    .rst_ni (reset_n),
    .d_i    (i2s_lrck),
    .q_o    (lrck_s)
  );

  sync_ff2 u_sync_sdin (
    .clk_i  (clk_74a),
    .rst_ni (reset_n),
    .d_i    (i2s_sdin),
    .q_o    (sdin_s)
  );

  logic                   sclk_prev_q;
  logic                   sclk_rise;
  logic                   primed_q, primed_d;
  logic                   lrck_prev_q, lrck_prev_d;
  channel_e               channel_q, channel_d;
  logic [CntW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_BITS-1:0] shift_q, shift_d;
  logic [SAMPLE_BITS-1:0] hold_left_q, hold_left_d;
  logic [SAMPLE_BITS-1:0] hold_right_q, hold_right_d;
  logic                   locked_q, locked_d;
  logic                   left_done_q, left_done_d;
  logic                   pair_done_q, pair_done_d;
  logic                   valid_q, valid_d;
  logic [SAMPLE_BITS-1:0] out_left_q, out_left_d;
  logic [SAMPLE_BITS-1:0] out_right_q, out_right_d;
  logic                   overrun_q, overrun_d;
  logic                   frame_err_q, frame_err_d;
  logic                   slot_err;
  logic                   drop_pair;
  logic [SAMPLE_BITS-1:0] word_next;

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign word_next = {shift_q[SAMPLE_BITS-2:0], sdin_s};

  // Slot tracking and bit capture; everything advances only on an SCLK rise.
  always_comb begin
    primed_d     = primed_q;
    lrck_prev_d  = lrck_prev_q;
    channel_d    = channel_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    hold_left_d  = hold_left_q;
    hold_right_d = hold_right_q;
    locked_d     = locked_q;
    left_done_d  = left_done_q;
    pair_done_d  = 1'b0;
    slot_err     = 1'b0;

    if (sclk_rise) begin
      if (!primed_q) begin
        // First rise after reset only learns the current LRCK level, so a
        // reset released mid-slot never looks like a fresh transition.
        primed_d    = 1'b1;
        lrck_prev_d = lrck_s;
      end else if (lrck_s != lrck_prev_q) begin
        lrck_prev_d = lrck_s;
        channel_d   = channel_e'(lrck_s);
        bit_cnt_d   = '0;
        locked_d    = 1'b1;
        if (!lrck_s) begin
          left_done_d = 1'b0;
        end
      end else begin
        if (bit_cnt_q != SlotMax) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end

        if (locked_q && (bit_cnt_q < SampleCnt)) begin
          shift_d = word_next;
          if (bit_cnt_q == LastBit) begin
            if (channel_q == ChLeft) begin
              hold_left_d = word_next;
              left_done_d = 1'b1;
            end else begin
              hold_right_d = word_next;
              if (left_done_q) begin
                pair_done_d = 1'b1;
                left_done_d = 1'b0;
              end
            end
          end
        end

        // A slot that runs to SLOT_BITS without a word-select change is lost.
        if (locked_q && (bit_cnt_q == SlotMax - 1'b1)) begin
          locked_d    = 1'b0;
          left_done_d = 1'b0;
          slot_err    = 1'b1;
        end
      end
    end
  end

  // Output handshake and sticky error flags.
  always_comb begin
    valid_d     = valid_q;
    out_left_d  = out_left_q;
    out_right_d = out_right_q;
    drop_pair   = 1'b0;

    if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end

    if (pair_done_q) begin
      if (!valid_q || sample_ready) begin
        out_left_d  = hold_left_q;
        out_right_d = hold_right_q;
        valid_d     = 1'b1;
      end else begin
        drop_pair = 1'b1;
      end
    end

    // A same-cycle set wins over err_clr.
    overrun_d   = drop_pair | (overrun_q & ~err_clr);
    frame_err_d = slot_err | (frame_err_q & ~err_clr);
  end

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      sclk_prev_q  <= 1'b0;
      primed_q     <= 1'b0;
      lrck_prev_q  <= 1'b0;
      channel_q    <= ChLeft;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      hold_left_q  <= '0;
      hold_right_q <= '0;
      locked_q     <= 1'b0;
      left_done_q  <= 1'b0;
      pair_done_q  <= 1'b0;
      valid_q      <= 1'b0;
      out_left_q   <= '0;
      out_right_q  <= '0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sclk_prev_q  <= sclk_s;
      primed_q     <= primed_d;
      lrck_prev_q  <= lrck_prev_d;
      channel_q    <= channel_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      hold_left_q  <= hold_left_d;
      hold_right_q <= hold_right_d;
      locked_q     <= locked_d;
      left_done_q  <= left_done_d;
      pair_done_q  <= pair_done_d;
      valid_q      <= valid_d;
      out_left_q   <= out_left_d;
      out_right_q  <= out_right_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign sample_left  = out_left_q;
  assign sample_right = out_right_q;
  assign sample_valid = valid_q;
  assign locked       = locked_q;
  assign overrun      = overrun_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: model I2S transmitter at SCLK = clk_74a/24.
module tb_i2s_receiver;

  logic        clk_74a = 1'b0;
  logic        reset_n;
  logic        i2s_sclk;
  logic        i2s_lrck;
  logic        i2s_sdin;
  logic [15:0] sample_left;
  logic [15:0] sample_right;
  logic        sample_valid;
  logic        sample_ready;
  logic        locked;
  logic        overrun;
  logic        frame_err;
  logic        err_clr;

  int checks   = 0;
  int failures = 0;
  int fe_cycles = 0;
  int fe_start;

  always #5 clk_74a = ~clk_74a;

  always @(posedge clk_74a) begin
    if (frame_err) fe_cycles++;
  end

  i2s_receiver #(
    .SAMPLE_BITS (16),
    .SLOT_BITS   (32)
  ) dut (
    .clk_74a      (clk_74a),
    .reset_n      (reset_n),
    .i2s_sclk     (i2s_sclk),
    .i2s_lrck     (i2s_lrck),
    .i2s_sdin     (i2s_sdin),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .locked       (locked),
    .overrun      (overrun),
    .frame_err    (frame_err),
    .err_clr      (err_clr)
  );

  typedef struct packed {
    logic [15:0] left;
    logic [15:0] right;
    logic        tail;
    logic [15:0] exp_left;
    logic [15:0] exp_right;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_74a);
    #2;
  endtask

  // One SCLK period: data and word select change on the falling edge.
  task automatic send_bit(input logic lr, input logic d);
    i2s_sclk = 1'b0;
    i2s_lrck = lr;
    i2s_sdin = d;
    tick(12);
    i2s_sclk = 1'b1;
    tick(12);
  endtask

  // 32-bit slot: bit 0 is the delay bit, bits 1..16 carry the word MSB first.
  task automatic send_slot(input logic lr, input logic [15:0] w, input logic tail);
    for (int i = 0; i < 32; i++) begin
      if (i >= 1 && i <= 16) send_bit(lr, w[16-i]);
      else send_bit(lr, tail);
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input logic tail);
    send_slot(1'b0, l, tail);
    send_slot(1'b1, r, tail);
  endtask

  task automatic consume(input string name);
    sample_ready = 1'b1;
    tick(1);
    sample_ready = 1'b0;
    tick(2);
    check(name, sample_valid, 1'b0);
  endtask

  initial begin
    vecs[0] = '{16'hA55A, 16'h1234, 1'b0, 16'hA55A, 16'h1234};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFF, 16'h0000};
    vecs[2] = '{16'h0001, 16'h8000, 1'b1, 16'h0001, 16'h8000};
    vecs[3] = '{16'h5A5A, 16'hC3C3, 1'b0, 16'h5A5A, 16'hC3C3};
    vecs[4] = '{16'h0000, 16'h7FFE, 1'b1, 16'h0000, 16'h7FFE};

    reset_n      = 1'b0;
    i2s_sclk     = 1'b1;
    i2s_lrck     = 1'b1;
    i2s_sdin     = 1'b0;
    sample_ready = 1'b0;
    err_clr      = 1'b0;
    tick(5);
    check("reset left", sample_left, 16'h0);
    check("reset right", sample_right, 16'h0);
    check("reset valid", sample_valid, 1'b0);
    check("reset locked", locked, 1'b0);
    check("reset overrun", overrun, 1'b0);
    check("reset frame_err", frame_err, 1'b0);
    reset_n = 1'b1;
    tick(5);

    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i].left, vecs[i].right, vecs[i].tail);
      tick(4);
      check($sformatf("vec%0d valid", i), sample_valid, 1'b1);
      check($sformatf("vec%0d left", i), sample_left, vecs[i].exp_left);
      check($sformatf("vec%0d right", i), sample_right, vecs[i].exp_right);
      check($sformatf("vec%0d locked", i), locked, 1'b1);
      check($sformatf("vec%0d overrun", i), overrun, 1'b0);
      check($sformatf("vec%0d frame_err", i), frame_err, 1'b0);
      consume($sformatf("vec%0d consume", i));
    end

    // Backpressure over two frames: first pair held, second dropped.
    send_frame(16'h1111, 16'h2222, 1'b0);
    check("bp1 valid", sample_valid, 1'b1);
    check("bp1 overrun", overrun, 1'b0);
    send_frame(16'h3333, 16'h4444, 1'b1);
    check("bp2 valid", sample_valid, 1'b1);
    check("bp2 left", sample_left, 16'h1111);
    check("bp2 right", sample_right, 16'h2222);
    check("bp2 overrun", overrun, 1'b1);

    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
    check("clr overrun", overrun, 1'b0);
    check("clr valid held", sample_valid, 1'b1);
    consume("clr consume");

    sample_ready = 1'b1;
    send_frame(16'h5555, 16'h6666, 1'b0);
    tick(2);
    check("rdy left", sample_left, 16'h5555);
    check("rdy right", sample_right, 16'h6666);
    check("rdy valid", sample_valid, 1'b0);
    check("rdy overrun", overrun, 1'b0);
    sample_ready = 1'b0;

    // Slot error: LRCK stays low for 40 SCLK periods.
    for (int i = 0; i < 32; i++) send_bit(1'b0, 1'b0);
    check("slot32 locked", locked, 1'b1);
    check("slot32 frame_err", frame_err, 1'b0);
    send_bit(1'b0, 1'b0);
    check("slot33 locked", locked, 1'b0);
    check("slot33 frame_err", frame_err, 1'b1);
    for (int i = 0; i < 7; i++) send_bit(1'b0, 1'b0);
    check("slot40 locked", locked, 1'b0);
    check("slot40 frame_err", frame_err, 1'b1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
    check("fe clr", frame_err, 1'b0);

    // Left slot has no transition, so this frame only relocks.
    send_frame(16'h7777, 16'h8888, 1'b0);
    check("relock valid", sample_valid, 1'b0);
    check("relock locked", locked, 1'b1);
    send_frame(16'h9ABC, 16'hDEF0, 1'b1);
    check("resume valid", sample_valid, 1'b1);
    check("resume left", sample_left, 16'h9ABC);
    check("resume right", sample_right, 16'hDEF0);
    consume("resume consume");

    // A slot error while err_clr is held: the set wins for exactly one cycle.
    err_clr  = 1'b1;
    fe_start = fe_cycles;
    for (int i = 0; i < 40; i++) send_bit(1'b0, 1'b0);
    err_clr = 1'b0;
    tick(1);
    check("prio fe cycles", fe_cycles - fe_start, 1);
    check("prio frame_err", frame_err, 1'b0);
    check("prio locked", locked, 1'b0);

    // Reset mid left slot with a pending pair and overrun set.
    send_frame(16'h1357, 16'h2468, 1'b0);
    send_frame(16'h0F0F, 16'hF0F0, 1'b0);
    send_frame(16'h1111, 16'h1111, 1'b0);
    check("pre-rst overrun", overrun, 1'b1);
    check("pre-rst left", sample_left, 16'h0F0F);
    for (int i = 0; i < 10; i++) send_bit(1'b0, 1'b1);
    reset_n = 1'b0;
    tick(3);
    check("rst left", sample_left, 16'h0);
    check("rst right", sample_right, 16'h0);
    check("rst valid", sample_valid, 1'b0);
    check("rst locked", locked, 1'b0);
    check("rst overrun", overrun, 1'b0);
    check("rst frame_err", frame_err, 1'b0);
    reset_n = 1'b1;
    tick(2);
    for (int i = 10; i < 32; i++) send_bit(1'b0, 1'b1);
    send_slot(1'b1, 16'hCAFE, 1'b0);
    check("post-rst valid", sample_valid, 1'b0);
    check("post-rst locked", locked, 1'b1);
    send_frame(16'hBEEF, 16'h4321, 1'b1);
    check("post-rst pair valid", sample_valid, 1'b1);
    check("post-rst pair left", sample_left, 16'hBEEF);
    check("post-rst pair right", sample_right, 16'h4321);
    check("post-rst overrun", overrun, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
